// File: rtl/queue_burst_drainer.sv
// rtl/queue_burst_drainer.sv - pulls a programmed burst of words from a REQ/ACK queue
// and forwards them through a one-entry valid/ready output stage with checksum and count.
module queue_burst_drainer #(
    parameter int BitWidth = 32,
    parameter int LenWidth = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start,
    input  logic [LenWidth-1:0] BurstLen,
    input  logic                Abort,
    input  logic                qACK,
    input  logic [BitWidth-1:0] qDATA,
    output logic                qREQ,
    output logic [BitWidth-1:0] dOUT,
    output logic                dOutValid,
    input  logic                dOutReady,
    output logic                Busy,
    output logic                Done,
    output logic                Aborted,
    output logic [LenWidth-1:0] WordCount,
    output logic [BitWidth-1:0] Checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t              r_state;
    logic [LenWidth-1:0] r_remaining;
    logic [LenWidth-1:0] r_word_count;
    logic [BitWidth-1:0] r_checksum;
    logic [BitWidth-1:0] r_dout;
    logic                r_dout_valid;
    logic                r_done;
    logic                r_aborted;

    logic                w_qxfer;
    logic                w_oxfer;

    // Request only when the output slot is free or is being emptied this cycle.
    assign qREQ    = (r_state == S_RUN) && (r_remaining != '0) && (!r_dout_valid || dOutReady);
    assign w_qxfer = qREQ && qACK;
    assign w_oxfer = r_dout_valid && dOutReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_word_count <= '0;
            r_checksum   <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            // Done follows the FIN cycle, so the pulse lands one cycle after FIN.
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_remaining  <= BurstLen;
                        r_word_count <= '0;
                        r_checksum   <= '0;
                        r_aborted    <= 1'b0;
                        r_state      <= (BurstLen == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_qxfer) begin
                        r_dout       <= qDATA;
                        r_dout_valid <= 1'b1;
                        r_remaining  <= r_remaining - LenWidth'(1);
                        r_word_count <= r_word_count + LenWidth'(1);
                        r_checksum   <= r_checksum + qDATA;
                    end else if (w_oxfer) begin
                        r_dout_valid <= 1'b0;
                    end
                    if (Abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DRAIN;
                    end else if (w_qxfer && (r_remaining == LenWidth'(1))) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_dout_valid || dOutReady) begin
                        r_dout_valid <= 1'b0;
                        r_state      <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dOUT      = r_dout;
    assign dOutValid = r_dout_valid;
    assign Busy      = (r_state != S_IDLE);
    assign Done      = r_done;
    assign Aborted   = r_aborted;
    assign WordCount = r_word_count;
    assign Checksum  = r_checksum;

endmodule

// File: tb/tb_queue_burst_drainer.sv
// tb/tb_queue_burst_drainer.sv - randomized bench for queue_burst_drainer against a
// queue-level burst model.
module tb_queue_burst_drainer;

    localparam int BW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Start = 1'b0;
    logic [LW-1:0] BurstLen = '0;
    logic          Abort = 1'b0;
    logic          qACK = 1'b0;
    logic [BW-1:0] qDATA = '0;
    logic          qREQ;
    logic [BW-1:0] dOUT;
    logic          dOutValid;
    logic          dOutReady = 1'b0;
    logic          Busy;
    logic          Done;
    logic          Aborted;
    logic [LW-1:0] WordCount;
    logic [BW-1:0] Checksum;

    queue_burst_drainer #(.BitWidth(BW), .LenWidth(LW)) dut (
        .clk(clk), .rst(rst), .Start(Start), .BurstLen(BurstLen), .Abort(Abort),
        .qACK(qACK), .qDATA(qDATA), .qREQ(qREQ), .dOUT(dOUT), .dOutValid(dOutValid),
        .dOutReady(dOutReady), .Busy(Busy), .Done(Done), .Aborted(Aborted),
        .WordCount(WordCount), .Checksum(Checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    logic [31:0] q[$];
    logic [31:0] outs[$];
    logic [31:0] exp_words[$];
    int cyc = 0, burst_cyc = 0, taken = 0, done_cnt = 0, done_cyc = 0;
    int first_o_cyc = -1, last_o_cyc = -1, qreq_cnt = 0, start_cyc = 0;
    int ready_mode = 0, ack_mode = 0, abort_at = 0;
    logic prev_stall = 1'b0, abort_chk = 1'b0;
    logic [31:0] prev_dout = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    function automatic logic ack_ok();
        case (ack_mode)
            0: return 1'b1;
            1: return (burst_cyc >= 10) && (((burst_cyc - 10) % 3) == 0);
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    function automatic logic ready_val();
        case (ready_mode)
            0: return 1'b1;
            1: return (burst_cyc % 3) == 0;
            default: return $urandom_range(0, 2) != 0;
        endcase
    endfunction

    task automatic drive_inputs();
        qACK      = (q.size() != 0) && ack_ok();
        qDATA     = (q.size() != 0) ? q[0] : $urandom();
        dOutReady = ready_val();
    endtask

    task automatic step();
        logic wq, wo;
        @(negedge clk);
        wq = qREQ && qACK;
        wo = dOutValid && dOutReady;
        if (dOutValid && !dOutReady) check("stall_qreq", 32'(qREQ), 32'd0);
        if (prev_stall) begin
            check("hold_valid", 32'(dOutValid), 32'd1);
            check("hold_data", dOUT, prev_dout);
        end
        if (abort_chk) begin
            check("abort_qreq_low", 32'(qREQ), 32'd0);
            abort_chk = 1'b0;
        end
        if (ack_mode == 1 && burst_cyc == 5) begin
            check("starve_busy", 32'(Busy), 32'd1);
            check("starve_qreq", 32'(qREQ), 32'd1);
        end
        prev_stall = dOutValid && !dOutReady;
        prev_dout  = dOUT;
        if (qREQ) qreq_cnt++;
        if (wo) begin
            outs.push_back(dOUT);
            if (first_o_cyc < 0) first_o_cyc = cyc;
            last_o_cyc = cyc;
        end
        if (Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (wq) begin
            taken++;
            if (taken == abort_at) begin
                Abort = 1'b1;
                abort_chk = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        Abort = 1'b0;
        if (wq) void'(q.pop_front());
        cyc++;
        burst_cyc++;
        drive_inputs();
    endtask

    task automatic run_burst(input int len, input int abt, input int rst_at);
        int n, qsize0;
        logic [31:0] sum;
        n = (abt > 0 && abt < len) ? abt : len;
        exp_words.delete();
        sum = '0;
        for (int i = 0; i < n; i++) begin
            exp_words.push_back(q[i]);
            sum = sum + q[i];
        end
        qsize0 = q.size();
        outs.delete();
        taken = 0; done_cnt = 0; first_o_cyc = -1; last_o_cyc = -1; qreq_cnt = 0;
        burst_cyc = 0; abort_at = abt; prev_stall = 1'b0; abort_chk = 1'b0;
        drive_inputs();
        Start = 1'b1;
        BurstLen = LW'(len);
        start_cyc = cyc;
        step();
        Start = 1'b0;
        for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
            step();
            if (rst_at > 0 && taken == rst_at) begin
                #1 rst = 1'b1;
                #1;
                check("rst_qreq", 32'(qREQ), 32'd0);
                check("rst_valid", 32'(dOutValid), 32'd0);
                check("rst_dout", dOUT, 32'd0);
                check("rst_busy", 32'(Busy), 32'd0);
                check("rst_wc", 32'(WordCount), 32'd0);
                check("rst_cs", Checksum, 32'd0);
                check("rst_flags", {30'd0, Done, Aborted}, 32'd0);
                check("rst_q_left", 32'(q.size()), 32'(qsize0 - rst_at));
                #1 rst = 1'b0;
                prev_stall = 1'b0;
                return;
            end
        end
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        for (int i = 0; i < 3; i++) step();
        check("done_once", 32'(done_cnt), 32'd1);
        check("idle_busy", 32'(Busy), 32'd0);
        check("out_count", 32'(outs.size()), 32'(n));
        for (int i = 0; i < n && i < outs.size(); i++) check("out_word", outs[i], exp_words[i]);
        check("word_count", 32'(WordCount), 32'(n));
        check("checksum", Checksum, sum);
        check("aborted", 32'(Aborted), 32'(abt > 0 && abt <= len));
        check("q_left", 32'(q.size()), 32'(qsize0 - n));
        if (len > 0) check("done_latency", 32'(done_cyc - last_o_cyc), 32'd2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_qreq", 32'(qREQ), 32'd0);
        check("reset_outs", {28'd0, dOutValid, Busy, Done, Aborted}, 32'd0);
        check("reset_data", dOUT | Checksum | 32'(WordCount), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // basic burst
        q = {32'h11, 32'h22, 32'h33};
        ready_mode = 0; ack_mode = 0;
        run_burst(3, 0, 0);
        check("basic_qreq_cycles", 32'(qreq_cnt), 32'd3);
        check("basic_out_span", 32'(last_o_cyc - first_o_cyc), 32'd2);
        check("basic_checksum", Checksum, 32'h66);

        // backpressure
        q = {32'hA1, 32'hB2, 32'hC3, 32'hD4};
        ready_mode = 1;
        run_burst(4, 0, 0);

        // starved queue
        q = {32'h1234, 32'h5678};
        ready_mode = 0; ack_mode = 1;
        run_burst(2, 0, 0);
        ack_mode = 0;

        // wrap and zero-length
        q = {32'hFFFF_FFFF, 32'h0000_0002};
        run_burst(2, 0, 0);
        check("wrap_checksum", Checksum, 32'h1);
        q = {32'h77};
        run_burst(0, 0, 0);
        check("zero_no_qreq", 32'(qreq_cnt), 32'd0);
        check("zero_done_latency", 32'(done_cyc - start_cyc), 32'd2);

        // abort on the 3rd queue transfer
        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(32'h100 + 32'(i));
        run_burst(10, 3, 0);
        q.delete();

        // reset mid-burst, then resume from the words left behind
        for (int i = 0; i < 5; i++) q.push_back(32'hC0DE_0000 + 32'(i));
        run_burst(5, 0, 2);
        run_burst(3, 0, 0);

        // randomized bursts
        for (int t = 0; t < 20; t++) begin
            int len, abt;
            len = $urandom_range(1, 12);
            abt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
            q.delete();
            for (int i = 0; i < len + $urandom_range(0, 3); i++) q.push_back($urandom());
            ready_mode = $urandom_range(0, 2);
            ack_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            run_burst(len, abt, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/queue_burst_drainer.md
Name: queue_burst_drainer

Overview:
- Consumer-side controller for the team's REQ/ACK FIFO read port: on command it pulls a programmed number of words from a queue and forwards each through a one-entry registered output stage with valid/ready.
- Keeps a running checksum and a transfer count, and signals completion with a one-cycle pulse.
- Sits between a FIFO read port and a downstream sink such as a DMA or serializer.

Parameters:
- BitWidth, 32, data word width; must match the queue's BitWidth.
- LenWidth, 8, width of the burst-length command and of WordCount.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- Start  input  1  burst command strobe; sampled only in IDLE
- BurstLen  input  LenWidth  words to read; sampled with Start
- Abort  input  1  stop the burst early; sampled only in RUN
- qACK  input  1  queue has data (FIFO dOutACK)
- qDATA  input  BitWidth  queue head word; valid while qACK=1
- qREQ  output  1  take head word (to FIFO dOutREQ)
- dOUT  output  BitWidth  registered output word
- dOutValid  output  1  dOUT holds an untransferred word
- dOutReady  input  1  sink accepts dOUT
- Busy  output  1  state is not IDLE
- Done  output  1  one-cycle completion pulse
- Aborted  output  1  last burst ended by Abort; held until next Start
- WordCount  output  LenWidth  words read from the queue in the current or last burst
- Checksum  output  BitWidth  sum modulo 2^BitWidth of words read in the current or last burst

Behaviour:
- Reset values: all outputs 0, state IDLE, remaining counter 0. dOUT register reset to 0. Reset is asynchronous and may occur mid-burst.
- A reset mid-burst discards dOUT. Words not yet taken stay in the queue.
- A queue transfer occurs on a posedge with qREQ=1 and qACK=1. qREQ never depends combinationally on qDATA.
- An output transfer occurs on a posedge with dOutValid=1 and dOutReady=1.
- States:
  - IDLE: on Start, load remaining=BurstLen, clear WordCount, Checksum and Aborted, go to RUN. If BurstLen=0, go to FIN instead.
  - RUN: qREQ = qACK-independent term (remaining!=0) && (!dOutValid || dOutReady), i.e. combinational on dOutReady, which gives full throughput.
    - On a queue transfer: dOUT<=qDATA, dOutValid<=1, remaining-=1, WordCount+=1, Checksum+=qDATA (wraps).
    - If an output transfer happens in the same cycle with no queue transfer, dOutValid<=0.
    - Go to DRAIN when remaining reaches 0 after a transfer.
    - Abort: go to DRAIN and set Aborted. If qREQ and qACK are both 1 in that cycle, the transfer still completes and is counted. qREQ is 0 from the next cycle.
  - DRAIN: qREQ=0. Hold dOUT until its output transfer, or go immediately if dOutValid=0, then go to FIN.
  - FIN: Done=1 for exactly one cycle, then go to IDLE. Busy=0 only in IDLE.
- WordCount and Checksum are stable from Done until the next accepted Start.
- Start outside IDLE and Abort outside RUN are ignored.
- qACK low stalls RUN indefinitely with no timeout. dOutReady low stalls with dOUT and dOutValid held stable.
- Latency, with Start on edge E0 and queue and sink always ready:
  - qREQ first high in the cycle after E0.
  - The first word appears on dOUT one cycle after its queue transfer.
  - Done is high 2 cycles after the edge carrying the final output transfer (DRAIN→FIN, FIN).
  - Throughput is 1 word/cycle.
- BurstLen maximum is 2^LenWidth-1. No wrap of remaining: the decrement is never applied at 0.

Test Plan:
- Basic burst: queue preloaded 0x11,0x22,0x33, BurstLen=3, dOutReady=1 → qREQ high 3 consecutive cycles; dOUT sequence 0x11,0x22,0x33 on consecutive cycles; one Done pulse; WordCount=3; Checksum=0x66; Aborted=0; 0 words left in queue.
- Backpressure: BurstLen=4, dOutReady toggles 1,0,0,1,… → dOUT held stable while not ready; no word lost or duplicated; qREQ=0 whenever dOutValid=1 and dOutReady=0; final order and Checksum match the preload.
- Starved queue: BurstLen=2, qACK=0 for 10 cycles then one word per 3 cycles → Busy stays 1 and qREQ stays high; Done only after the second word's output transfer; WordCount=2.
- Wrap and zero-length: words 0xFFFFFFFF and 0x00000002 give Checksum=0x00000001. BurstLen=0 → Done two cycles after Start, no qREQ, WordCount=0, Checksum=0.
- Abort: BurstLen=10, assert Abort in the cycle of the 3rd queue transfer → WordCount=3; qREQ low from the next cycle; 3rd word still delivered; Done with Aborted=1; 7 words remain in queue.
- Reset mid-burst: rst pulse after 2 of 5 words, asynchronous mid-cycle → all outputs 0 immediately; queue retains 3 words. A new Start with BurstLen=3 reads them correctly.
